laser_pool: RTL and testbench

- Multi-shot successor to the single-laser block.
- Manages a pool of NUM_SHOTS independent player lasers: slot allocation on fire, shot cooldown, per-tick vertical motion, alien-kill retirement, and per-pixel circular hit test for VGA colour.
- Sits between the ship/gun controller (fire, gun_x), the alien collision logic (kill_valid/kill_idx, shot coordinates) and the VGA colour mux (color).

---
 rtl/game_pkg.sv | 14 +
 rtl/laser_pool_pkg.sv | 13 +
 rtl/laser_pool_if.sv | 12 +
 rtl/laser_slot.sv | 86 ++++++++
 rtl/laser_pool.sv | 114 +++++++++++
 tb/tb_laser_pool.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/game_pkg.sv
// Screen geometry and colour codes shared by the game video blocks.
package game_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int SHIP_HEIGHT = 30;
   localparam int V_OFFSET    = 10;

   localparam logic [2:0] BG_COLOR    = 3'd0;
   localparam logic [2:0] LASER_COLOR = 3'd6;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/laser_pool_pkg.sv
// Laser pool helpers: spawn height and parked coordinates.
package laser_pool_pkg;
   import game_pkg::*;

   localparam coord_t PARK_X = coord_t'(SCREEN_W - 1);
   localparam coord_t PARK_Y = coord_t'(SCREEN_H - 1);

   // New shots appear just above the ship, one radius clear of its top edge.
   function automatic int calc_spawn_y(input int radius);
      return SCREEN_H - V_OFFSET - SHIP_HEIGHT - radius;
   endfunction

endpackage

// File: rtl/laser_pool_if.sv
// Gun controller to laser pool fire handshake.
interface laser_pool_if;
   import game_pkg::*;

   logic   fire;
   coord_t gun_x;
   logic   fire_ack;

   modport master (output fire, output gun_x, input fire_ack);
   modport slave  (input fire, input gun_x, output fire_ack);

endinterface

// File: rtl/laser_slot.sv
// One laser slot: position registers, spawn/kill/motion update and disc hit test.
module laser_slot
   import game_pkg::*;
   import laser_pool_pkg::*;
#(
   parameter int RADIUS  = 4,
   parameter int STEP    = 1,
   parameter int SPAWN_Y = 436
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   enable,
   input  logic   spawn,
   input  logic   kill,
   input  coord_t spawn_x,
   input  coord_t h_pos,
   input  coord_t v_pos,
   output logic   alive,
   output coord_t x,
   output coord_t y,
   output logic   hit
);

   localparam coord_t             STEP_C  = coord_t'(STEP);
   localparam coord_t             SPAWN_C = coord_t'(SPAWN_Y);
   localparam logic signed [21:0] R2      = 22'(RADIUS * RADIUS);

   logic   alive_q, alive_d;
   coord_t x_q, x_d;
   coord_t y_q, y_d;

   logic signed [10:0] dx, dy;
   logic signed [21:0] dx_e, dy_e, dist2;

   // Next-state: kill beats spawn and motion; a freshly spawned shot holds still.
   always_comb begin
      alive_d = alive_q;
      x_d     = x_q;
      y_d     = y_q;
      if (kill && alive_q) begin
         alive_d = 1'b0;
         x_d     = PARK_X;
         y_d     = PARK_Y;
      end else if (spawn && !alive_q) begin
         alive_d = 1'b1;
         x_d     = spawn_x;
         y_d     = SPAWN_C;
      end else if (enable && alive_q) begin
         if (y_q >= STEP_C) begin
            y_d = y_q - STEP_C;
         end else begin
            alive_d = 1'b0;
            x_d     = PARK_X;
            y_d     = PARK_Y;
         end
      end
   end

   // Slot registers with synchronous reset to the parked position.
   always_ff @(posedge clk) begin
      if (reset) begin
         alive_q <= 1'b0;
         x_q     <= PARK_X;
         y_q     <= PARK_Y;
      end else begin
         alive_q <= alive_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // Squared distance from the current pixel to the disc centre.
   always_comb begin
      dx    = $signed({1'b0, h_pos}) - $signed({1'b0, x_q});
      dy    = $signed({1'b0, v_pos}) - $signed({1'b0, y_q});
      dx_e  = 22'(dx);
      dy_e  = 22'(dy);
      dist2 = dx_e * dx_e + dy_e * dy_e;
      hit   = alive_q && (dist2 <= R2);
   end

   assign alive = alive_q;
   assign x     = x_q;
   assign y     = y_q;

endmodule

// File: rtl/laser_pool.sv
// Pool of player lasers: slot allocation, fire cooldown and pixel colour.
module laser_pool
   import game_pkg::*;
   import laser_pool_pkg::*;
#(
   parameter  int NUM_SHOTS = 4,
   parameter  int RADIUS    = 4,
   parameter  int STEP      = 1,
   parameter  int COOLDOWN  = 16,
   localparam int IW        = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   laser_pool_if.slave             gun,
   input  logic                    kill_valid,
   input  logic [IW-1:0]           kill_idx,
   input  coord_t                  h_pos,
   input  coord_t                  v_pos,
   output logic [2:0]              color,
   output logic [NUM_SHOTS-1:0]    alive,
   output logic [10*NUM_SHOTS-1:0] x_flat,
   output logic [10*NUM_SHOTS-1:0] y_flat
);

   localparam int SPAWN_Y = calc_spawn_y(RADIUS);
   localparam int CW      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic [NUM_SHOTS-1:0] spawn_vec;
   logic [NUM_SHOTS-1:0] kill_vec;
   logic [NUM_SHOTS-1:0] hit_vec;
   logic                 fire_ok;
   logic                 found;

   logic [CW-1:0] cool_q, cool_d;
   logic          fire_ack_q, fire_ack_d;
   logic [2:0]    color_q, color_d;

   // Accept a fire only with a free slot at cycle start and no cooldown pending.
   assign fire_ok = enable && gun.fire && (cool_q == '0) && !(&alive);

   // Lowest-index free slot gets the new shot.
   always_comb begin
      spawn_vec = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         if (!alive[i] && !found) begin
            spawn_vec[i] = fire_ok;
            found        = 1'b1;
         end
      end
   end

   // Decode the kill index; out-of-range indices match no slot.
   always_comb begin
      kill_vec = '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         kill_vec[i] = kill_valid && (32'(kill_idx) == i);
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_SHOTS; g++) begin : g_slot
         laser_slot #(
            .RADIUS  (RADIUS),
            .STEP    (STEP),
            .SPAWN_Y (SPAWN_Y)
         ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .spawn   (spawn_vec[g]),
            .kill    (kill_vec[g]),
            .spawn_x (gun.gun_x),
            .h_pos   (h_pos),
            .v_pos   (v_pos),
            .alive   (alive[g]),
            .x       (x_flat[10*g +: 10]),
            .y       (y_flat[10*g +: 10]),
            .hit     (hit_vec[g])
         );
      end
   endgenerate

   // Cooldown down-counter, fire ack and colour next-state.
   always_comb begin
      cool_d = cool_q;
      if (fire_ok) begin
         cool_d = CW'(COOLDOWN);
      end else if (enable && (cool_q != '0)) begin
         cool_d = cool_q - 1'b1;
      end
      fire_ack_d = fire_ok;
      color_d    = (|hit_vec) ? LASER_COLOR : BG_COLOR;
   end

   // Top-level registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cool_q     <= '0;
         fire_ack_q <= 1'b0;
         color_q    <= BG_COLOR;
      end else begin
         cool_q     <= cool_d;
         fire_ack_q <= fire_ack_d;
         color_q    <= color_d;
      end
   end

   assign gun.fire_ack = fire_ack_q;
   assign color        = color_q;

endmodule

// File: tb/tb_laser_pool.sv
// Directed bench for laser_pool: three instances cover COOLDOWN=0, COOLDOWN=16 and STEP=2.
module tb_laser_pool;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       reset, enable, fire, kill_valid;
   logic [1:0] kill_idx;
   coord_t     gun_x, h_pos, v_pos;

   int vecs = 0;
   int errs = 0;

   logic [2:0]  color0, color1, color2;
   logic [3:0]  alive0, alive1, alive2;
   logic [39:0] xf0, yf0, xf1, yf1, xf2, yf2;

   laser_pool_if if0 ();
   laser_pool_if if1 ();
   laser_pool_if if2 ();

   assign if0.fire  = fire;
   assign if0.gun_x = gun_x;
   assign if1.fire  = fire;
   assign if1.gun_x = gun_x;
   assign if2.fire  = fire;
   assign if2.gun_x = gun_x;

   always #5 clk = ~clk;

   laser_pool #(.NUM_SHOTS(4), .RADIUS(4), .STEP(1), .COOLDOWN(0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .gun(if0.slave),
      .kill_valid(kill_valid), .kill_idx(kill_idx), .h_pos(h_pos), .v_pos(v_pos),
      .color(color0), .alive(alive0), .x_flat(xf0), .y_flat(yf0));

   laser_pool #(.NUM_SHOTS(4), .RADIUS(4), .STEP(1), .COOLDOWN(16)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .gun(if1.slave),
      .kill_valid(kill_valid), .kill_idx(kill_idx), .h_pos(h_pos), .v_pos(v_pos),
      .color(color1), .alive(alive1), .x_flat(xf1), .y_flat(yf1));

   laser_pool #(.NUM_SHOTS(4), .RADIUS(4), .STEP(2), .COOLDOWN(0)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .gun(if2.slave),
      .kill_valid(kill_valid), .kill_idx(kill_idx), .h_pos(h_pos), .v_pos(v_pos),
      .color(color2), .alive(alive2), .x_flat(xf2), .y_flat(yf2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; fire = 1'b1; kill_valid = 1'b0; kill_idx = 2'd0;
      gun_x = 10'd50; h_pos = 10'd0; v_pos = 10'd0;
      #1;
      step();
      step();
      // fire during reset is discarded
      chk("rst_alive", 64'(alive0), 64'd0);
      chk("rst_ack", 64'(if0.fire_ack), 64'd0);
      chk("rst_x", 64'(xf0), 64'({4{10'd639}}));
      chk("rst_y", 64'(yf0), 64'({4{10'd479}}));
      chk("rst_color", 64'(color0), 64'd0);
      reset = 1'b0; fire = 1'b0; enable = 1'b0;
      step();
      chk("idle_alive", 64'(alive0), 64'd0);
      chk("idle_color", 64'(color0), 64'd0);

      // single shot, then ten enable ticks of motion
      fire = 1'b1; enable = 1'b1; gun_x = 10'd200;
      step();
      chk("fire_ack", 64'(if0.fire_ack), 64'd1);
      chk("fire_alive", 64'(alive0), 64'b0001);
      chk("fire_x0", 64'(xf0[9:0]), 64'd200);
      chk("fire_y0", 64'(yf0[9:0]), 64'd436);
      fire = 1'b0;
      step();
      chk("ack_pulse", 64'(if0.fire_ack), 64'd0);
      for (int i = 0; i < 9; i++) step();
      chk("move_y0", 64'(yf0[9:0]), 64'd426);

      // fill the pool
      fire = 1'b1;
      gun_x = 10'd300; step();
      chk("fill1_alive", 64'(alive0), 64'b0011);
      gun_x = 10'd400; step();
      gun_x = 10'd500; step();
      chk("fill3_alive", 64'(alive0), 64'b1111);
      chk("fill3_x3", 64'(xf0[39:30]), 64'd500);
      chk("fill3_y3", 64'(yf0[39:30]), 64'd436);
      gun_x = 10'd600; step();
      chk("full_ack", 64'(if0.fire_ack), 64'd0);
      chk("full_alive", 64'(alive0), 64'b1111);

      // kill slot 2 without a tick, then refire into it
      fire = 1'b0; enable = 1'b0; kill_valid = 1'b1; kill_idx = 2'd2;
      step();
      chk("kill_alive", 64'(alive0), 64'b1011);
      chk("kill_x2", 64'(xf0[29:20]), 64'd639);
      chk("kill_y2", 64'(yf0[29:20]), 64'd479);
      kill_valid = 1'b0; fire = 1'b1; enable = 1'b1; gun_x = 10'd77;
      step();
      chk("refire_ack", 64'(if0.fire_ack), 64'd1);
      chk("refire_alive", 64'(alive0), 64'b1111);
      chk("refire_x2", 64'(xf0[29:20]), 64'd77);

      // cooldown: fire held every tick, acks only on ticks 0, 17, 34
      reset = 1'b1; fire = 1'b0; step();
      reset = 1'b0; fire = 1'b1; enable = 1'b1; gun_x = 10'd10;
      for (int t = 0; t < 40; t++) begin
         step();
         chk($sformatf("cool_ack_t%0d", t), 64'(if1.fire_ack),
             64'((t == 0) || (t == 17) || (t == 34)));
      end
      chk("cool_alive", 64'(alive1), 64'b0111);

      // STEP=2: a shot reaching y=0 retires on the next tick
      reset = 1'b1; fire = 1'b0; step();
      reset = 1'b0; fire = 1'b1; gun_x = 10'd123;
      step();
      fire = 1'b0;
      for (int i = 0; i < 217; i++) step();
      chk("s2_y2", 64'(yf2[9:0]), 64'd2);
      step();
      chk("s2_y0", 64'(yf2[9:0]), 64'd0);
      chk("s2_alive_at0", 64'(alive2), 64'b0001);
      step();
      chk("s2_retire_alive", 64'(alive2), 64'b0000);
      chk("s2_retire_x", 64'(xf2[9:0]), 64'd639);
      chk("s2_retire_y", 64'(yf2[9:0]), 64'd479);

      // kill and fire together with a full pool
      reset = 1'b1; step();
      reset = 1'b0; fire = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("kf_full", 64'(alive0), 64'b1111);
      kill_valid = 1'b1; kill_idx = 2'd1;
      step();
      chk("kf_ack", 64'(if0.fire_ack), 64'd0);
      chk("kf_alive", 64'(alive0), 64'b1101);
      kill_valid = 1'b0;
      step();
      chk("kf_next_ack", 64'(if0.fire_ack), 64'd1);
      chk("kf_next_alive", 64'(alive0), 64'b1111);

      // pixel sweep around a shot parked at (100,200)
      reset = 1'b1; fire = 1'b0; step();
      reset = 1'b0; fire = 1'b1; gun_x = 10'd100;
      step();
      fire = 1'b0;
      for (int i = 0; i < 236; i++) step();
      enable = 1'b0;
      chk("pix_y0", 64'(yf0[9:0]), 64'd200);
      h_pos = 10'd104; v_pos = 10'd200; step();
      chk("pix_104_200", 64'(color0), 64'd6);
      h_pos = 10'd100; v_pos = 10'd196; step();
      chk("pix_100_196", 64'(color0), 64'd6);
      h_pos = 10'd104; v_pos = 10'd201; step();
      chk("pix_104_201", 64'(color0), 64'd0);
      h_pos = 10'd103; v_pos = 10'd203; step();
      chk("pix_103_203", 64'(color0), 64'd0);
      h_pos = 10'd96; v_pos = 10'd200; step();
      chk("pix_96_200", 64'(color0), 64'd6);
      h_pos = 10'd95; v_pos = 10'd200; step();
      chk("pix_95_200", 64'(color0), 64'd0);

      // kill aimed at a dead slot is ignored
      kill_valid = 1'b1; kill_idx = 2'd3; step();
      chk("kill_dead", 64'(alive0), 64'b0001);
      kill_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
